// File: rtl/divider_arb_wrap.sv
// divider_arb_wrap: round-robin sharing of one pipelined divider among NCH channels, with tagged result return.
module divider_arb_wrap #(
  parameter int WIDTH = 48,
  parameter int NCH   = 4,
  parameter int LAT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_req,
  input  logic [NCH*WIDTH-1:0] in_dividend,
  input  logic [NCH*WIDTH-1:0] in_divider,
  output logic [NCH-1:0]       op_gnt,
  output logic [WIDTH-1:0]     op_dividerIn1,
  output logic [WIDTH-1:0]     op_dividerIn2,
  output logic                 op_dividerValid,
  input  logic [WIDTH-1:0]     in_outputOfDivider,
  output logic [NCH*WIDTH-1:0] op_dividerResult,
  output logic [NCH-1:0]       op_resultValid,
  output logic [NCH-1:0]       op_divByZero
);
  localparam int PW = $clog2(NCH);
  typedef struct packed {
    logic          v;
    logic [PW-1:0] ch;
    logic          dbz;
  } tag_t;
  logic [PW-1:0]        ptr_q, ptr_d, gch;
  logic                 found;
  logic [NCH-1:0]       gnt;
  logic [WIDTH-1:0]     dvd_d, dvs_d, in1_q, in2_q;
  logic                 vld_q;
  tag_t                 tag_d;
  tag_t                 tag_q [LAT+1];
  logic [NCH*WIDTH-1:0] res_q;
  logic [NCH-1:0]       rv_q, dbz_q;
  int                   k;
  // Scan channels starting at the pointer; the first requester wins.
  always_comb begin
    gnt = '0;
    gch = '0;
    found = 1'b0;
    dvd_d = '0;
    dvs_d = '0;
    k = 0;
    for (int i = 0; i < NCH; i++) begin
      k = (int'(ptr_q) + i) % NCH;
      if (!found && !rst && in_req[k]) begin
        found = 1'b1;
        gnt[k] = 1'b1;
        gch = PW'(k);
        dvd_d = in_dividend[k*WIDTH +: WIDTH];
        dvs_d = in_divider[k*WIDTH +: WIDTH];
      end
    end
    ptr_d = !found ? ptr_q : (int'(gch) == NCH - 1) ? '0 : gch + 1'b1;
    tag_d = '{v: found, ch: gch, dbz: found && dvs_d == '0};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      vld_q <= 1'b0;
      res_q <= '0;
      rv_q  <= '0;
      dbz_q <= '0;
      for (int j = 0; j <= LAT; j++) tag_q[j] <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= found;
      if (found) begin
        in1_q <= dvd_d;
        in2_q <= dvs_d;
      end
      tag_q[0] <= tag_d;
      for (int j = 1; j <= LAT; j++) tag_q[j] <= tag_q[j-1];
      rv_q <= '0;
      // The last tag stage lines up with the quotient on in_outputOfDivider.
      if (tag_q[LAT].v) begin
        res_q[int'(tag_q[LAT].ch)*WIDTH +: WIDTH] <= tag_q[LAT].dbz ? '1 : in_outputOfDivider;
        rv_q[tag_q[LAT].ch]  <= 1'b1;
        dbz_q[tag_q[LAT].ch] <= tag_q[LAT].dbz;
      end
    end
  end
  assign op_gnt           = gnt;
  assign op_dividerIn1    = in1_q;
  assign op_dividerIn2    = in2_q;
  assign op_dividerValid  = vld_q;
  assign op_dividerResult = res_q;
  assign op_resultValid   = rv_q;
  assign op_divByZero     = dbz_q;
endmodule

// File: doc/divider_arb_wrap.md
Name: divider_arb_wrap

Overview:
- Shares one external fully-pipelined 48-bit divider among NCH requesting channels.
- Round-robin arbitration selects one channel per cycle. The block registers that channel's operands into the divider and carries a channel tag alongside the divider latency.
- When the result emerges, the block steers it back to the owning channel with a one-cycle valid pulse.
- Divide-by-zero is detected and flagged; the forced result does not depend on the external divider.

Parameters:
- WIDTH, 48, operand and result width in bits.
- NCH, 4, number of requesting channels (2..16).
- LAT, 8, external divider latency in cycles from operand-valid to result (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_req  in  NCH  per-channel request; must stay high, with operands stable, until granted.
- in_dividend  in  NCH*WIDTH  per-channel dividend; channel k occupies bits [k*WIDTH +: WIDTH].
- in_divider  in  NCH*WIDTH  per-channel divisor, same packing.
- op_gnt  out  NCH  one-hot grant, combinational, asserted in the cycle the request is accepted.
- op_dividerIn1  out  WIDTH  registered dividend to the divider.
- op_dividerIn2  out  WIDTH  registered divisor to the divider.
- op_dividerValid  out  1  qualifies op_dividerIn1/op_dividerIn2.
- in_outputOfDivider  in  WIDTH  divider quotient, valid exactly LAT cycles after op_dividerValid.
- op_dividerResult  out  NCH*WIDTH  per-channel result holding registers, same packing.
- op_resultValid  out  NCH  one-cycle pulse per channel when its result register updates.
- op_divByZero  out  NCH  per-channel flag; meaningful in the op_resultValid cycle, then held.

Behaviour:
- Reset (rst=1 at a clock edge) clears the following to 0:
  - op_dividerIn1, op_dividerIn2, op_dividerValid;
  - op_dividerResult, op_resultValid, op_divByZero;
  - the tag pipeline;
  - the round-robin pointer (points at channel 0).
- Reset in mid-operation: all in-flight operations are dropped and no op_resultValid pulse fires for them. op_gnt is 0 while rst=1.
- Arbitration:
  - Round-robin starting at pointer p; grant the first k in p, p+1, ..., NCH-1, 0, ... with in_req[k]=1.
  - At most one grant per cycle.
  - After a grant to k, p becomes (k+1) mod NCH. With no grant, p is unchanged.
  - The divider is never stalled, so a request is granted within NCH cycles of assertion.
- Issue (grant to channel k in cycle t): at edge t+1 the block registers:
  - op_dividerIn1 = dividend[k], op_dividerIn2 = divisor[k], op_dividerValid = 1;
  - tag {valid=1, ch=k, dbz=(divisor[k]==0)} into pipeline stage 0.
- With no grant, op_dividerValid = 0 next cycle. Operand registers hold their previous values.
- Tag pipeline: LAT+1 stages shifting every cycle, so the tag is aligned with in_outputOfDivider, which is valid in cycle t+1+LAT.
- Return (at edge t+2+LAT, if the tag is valid):
  - op_dividerResult[k] = dbz ? all-ones : in_outputOfDivider;
  - op_divByZero[k] = dbz;
  - op_resultValid[k] = 1 for one cycle.
- Other channels' result registers are unchanged.
- Total latency from grant to op_resultValid = LAT+2 cycles.
- Back-to-back grants to the same channel are legal. Results return in issue order, one per cycle; each overwrites the holding register and pulses valid again.
- Simultaneous return and new issue in the same cycle are independent; there is no conflict.
- Arithmetic: unsigned. No width extension or truncation in the block; quotient width = WIDTH.

Test Plan:
- Single request: in_req=0001, ch0 dividend=100, divisor=7; grant in cycle 0 -> op_dividerValid in cycle 1 with In1=100, In2=7. Model returns 14 at cycle 9 -> op_resultValid=0001 and op_dividerResult[ch0]=14 at cycle 10.
- All four channels request continuously -> grants cycle 0,1,2,3,0,... as 0001,0010,0100,1000,0001. Each result is routed to the correct channel in issue order, one per cycle.
- Divisor 0 on ch2 (dividend=55) -> op_divByZero[2]=1 and result 0xFFFF_FFFF_FFFF at LAT+2; other channels' flags stay 0.
- Pointer at ch3, requests on ch1 and ch3 -> ch3 granted first, then ch1. A late-arriving ch0 request is granted after ch1.
- rst pulsed 3 cycles after issuing two operations -> no op_resultValid ever fires for them; all outputs read 0; the first post-reset grant goes to the lowest requesting channel.
- LAT=1, NCH=2 build -> operations issued back-to-back alternate channels, and results appear 3 cycles after each grant.
